// File: rtl/flappy_input_pkg.sv
// Shared types and joystick bit positions for the Flappy input conditioner.
package flappy_input_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    FIRE    = 2'd2,
    RELEASE = 2'd3
  } rst_state_t;

  localparam int JOY_FLAP  = 4;
  localparam int JOY_RESET = 5;

endpackage

// File: rtl/flappy_input_cond_debounce.sv
// Two-flop synchroniser followed by a stable-for-N-cycles debouncer.
module input_debounce #(
  parameter int DB_CYCLES = 240000
) (
  input  logic clk,
  input  logic sys_reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_state;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!sys_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      // Any return to the stable level restarts the count, so glitches never accumulate.
      if (r_sync2 == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_state <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout = r_state;

endmodule

// File: rtl/flappy_input_cond.sv
// Flap/reset button conditioning: OSD masking, debounce, flap strobe/counter and long-press reset pulse.
module flappy_input_cond
  import flappy_input_pkg::*;
#(
  parameter int DB_CYCLES    = 240000,
  parameter int HOLD_CYCLES  = 24000000,
  parameter int PULSE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        sys_reset,
  input  logic [31:0] joy_in,
  input  logic        osd_active,
  output logic        button_n,
  output logic        reset_req_n,
  output logic        flap_pulse,
  output logic [15:0] flap_count
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [HCW-1:0] HCNT_MAX = HCW'(HOLD_CYCLES - 1);
  localparam logic [PCW-1:0] PCNT_MAX = PCW'(PULSE_CYCLES - 1);

  logic       w_raw_flap;
  logic       w_raw_reset;
  logic       w_db_flap;
  logic       w_db_reset;
  logic       w_flap_pulse;
  logic       w_unused_joy;

  logic        r_db_flap_q;
  logic [15:0] r_flap_count;

  rst_state_t     r_state;
  rst_state_t     w_state_next;
  logic [HCW-1:0] r_hcnt;
  logic [PCW-1:0] r_pcnt;
  logic           r_reset_req_n;
  logic           w_reset_req_n_next;

  // OSD masking makes both buttons look released; they then debounce out normally.
  assign w_raw_flap   = osd_active ? 1'b0 : joy_in[JOY_FLAP];
  assign w_raw_reset  = osd_active ? 1'b0 : joy_in[JOY_RESET];
  assign w_unused_joy = ^{joy_in[31:6], joy_in[3:0]};

  input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_flap (
    .clk       (clk),
    .sys_reset (sys_reset),
    .din       (w_raw_flap),
    .dout      (w_db_flap)
  );

  input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
    .clk       (clk),
    .sys_reset (sys_reset),
    .din       (w_raw_reset),
    .dout      (w_db_reset)
  );

  assign w_flap_pulse = w_db_flap & ~r_db_flap_q;

  always_ff @(posedge clk) begin
    if (!sys_reset) begin
      r_db_flap_q  <= 1'b0;
      r_flap_count <= '0;
    end else begin
      r_db_flap_q <= w_db_flap;
      if (w_flap_pulse) begin
        r_flap_count <= r_flap_count + 16'd1;
      end
    end
  end

  // Reset FSM: state register and counters.
  always_ff @(posedge clk) begin
    if (!sys_reset) begin
      r_state       <= IDLE;
      r_hcnt        <= '0;
      r_pcnt        <= '0;
      r_reset_req_n <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_hcnt        <= (r_state == ARM && w_state_next == ARM) ? r_hcnt + 1'b1 : '0;
      r_pcnt        <= (r_state == FIRE && w_state_next == FIRE) ? r_pcnt + 1'b1 : '0;
      r_reset_req_n <= w_reset_req_n_next;
    end
  end

  // Reset FSM: next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_db_reset) w_state_next = ARM;
      end
      ARM: begin
        if (!w_db_reset)            w_state_next = IDLE;
        else if (r_hcnt == HCNT_MAX) w_state_next = FIRE;
      end
      FIRE: begin
        // The pulse always runs to full length, even if the button is let go.
        if (r_pcnt == PCNT_MAX) w_state_next = RELEASE;
      end
      RELEASE: begin
        if (!w_db_reset) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Reset FSM: output logic, registered so the request is glitch-free.
  always_comb begin
    w_reset_req_n_next = (w_state_next != FIRE);
  end

  assign button_n    = ~w_db_flap;
  assign flap_pulse  = w_flap_pulse;
  assign flap_count  = r_flap_count;
  assign reset_req_n = r_reset_req_n;

endmodule

// File: tb/tb_flappy_input_cond.sv
// Directed bench for flappy_input_cond with DB_CYCLES=4, HOLD_CYCLES=8, PULSE_CYCLES=3.
module tb_flappy_input_cond;
  import flappy_input_pkg::*;

  logic        clk = 1'b0;
  logic        sys_reset;
  logic [31:0] joy_in;
  logic        osd_active;
  logic        button_n;
  logic        reset_req_n;
  logic        flap_pulse;
  logic [15:0] flap_count;

  int total = 0;
  int bad   = 0;

  flappy_input_cond #(
    .DB_CYCLES    (4),
    .HOLD_CYCLES  (8),
    .PULSE_CYCLES (3)
  ) dut (
    .clk         (clk),
    .sys_reset   (sys_reset),
    .joy_in      (joy_in),
    .osd_active  (osd_active),
    .button_n    (button_n),
    .reset_req_n (reset_req_n),
    .flap_pulse  (flap_pulse),
    .flap_count  (flap_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    sys_reset  = 1'b0;
    joy_in     = 32'h0;
    osd_active = 1'b0;
    idle(3);
    check("rst_button_n", 32'(button_n), 32'd1);
    check("rst_reset_req_n", 32'(reset_req_n), 32'd1);
    check("rst_flap_pulse", 32'(flap_pulse), 32'd0);
    check("rst_flap_count", 32'(flap_count), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    sys_reset = 1'b1;
    idle(2);

    // 3-cycle glitches on flap never get through
    for (int g = 0; g < 10; g++) begin
      joy_in[4] = 1'b1;
      for (int e = 0; e < 3; e++) begin
        step();
        check("glitch_button_n", 32'(button_n), 32'd1);
      end
      joy_in[4] = 1'b0;
      for (int e = 0; e < 3; e++) begin
        step();
        check("glitch_button_n", 32'(button_n), 32'd1);
      end
    end
    idle(6);
    check("glitch_count", 32'(flap_count), 32'd0);
    $display("glitch test: 10 glitches, flap_count=%0d", flap_count);

    // Held flap press: button_n falls at edge 5, pulse for one cycle, count 0->1
    joy_in[4] = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      check("press_button_n", 32'(button_n), (e >= 5) ? 32'd0 : 32'd1);
      check("press_pulse", 32'(flap_pulse), (e == 5) ? 32'd1 : 32'd0);
      check("press_count", 32'(flap_count), (e >= 6) ? 32'd1 : 32'd0);
    end
    $display("flap press: button_n=%0b flap_count=%0d", button_n, flap_count);
    joy_in[4] = 1'b0;
    idle(10);
    check("release_button_n", 32'(button_n), 32'd1);

    // Long reset press: low for edges 14..16, only once while held
    joy_in[5] = 1'b1;
    for (int e = 0; e < 40; e++) begin
      step();
      check("hold_reset_req_n", 32'(reset_req_n), (e >= 14 && e <= 16) ? 32'd0 : 32'd1);
    end
    check("hold_state_release", 32'(dut.r_state), 32'(RELEASE));
    $display("reset hold: one pulse, state=%0d", dut.r_state);
    joy_in[5] = 1'b0;
    idle(10);
    check("unhold_state", 32'(dut.r_state), 32'(IDLE));
    joy_in[5] = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      check("repress_reset_req_n", 32'(reset_req_n), (e >= 14 && e <= 16) ? 32'd0 : 32'd1);
    end
    $display("reset re-press: second pulse checked");
    joy_in[5] = 1'b0;
    idle(10);

    // OSD opens during ARM: reset never fires
    joy_in[5] = 1'b1;
    for (int e = 0; e < 30; e++) begin
      step();
      if (e == 6) osd_active = 1'b1;
      if (e == 8) check("osd_state_arm", 32'(dut.r_state), 32'(ARM));
      check("osd_reset_req_n", 32'(reset_req_n), 32'd1);
    end
    check("osd_state_idle", 32'(dut.r_state), 32'(IDLE));
    $display("osd during arm: state=%0d reset_req_n=%0b", dut.r_state, reset_req_n);
    joy_in[5]  = 1'b0;
    osd_active = 1'b0;
    idle(10);

    // Counter wrap from 0xFFFF
    force dut.r_flap_count = 16'hFFFF;
    #1;
    release dut.r_flap_count;
    joy_in[4] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      check("wrap_pulse", 32'(flap_pulse), (e == 5) ? 32'd1 : 32'd0);
      check("wrap_count", 32'(flap_count), (e >= 6) ? 32'd0 : 32'hFFFF);
    end
    $display("counter wrap: flap_count=%0h", flap_count);
    joy_in[4] = 1'b0;
    idle(10);

    // Both buttons together, then system reset mid-FIRE
    joy_in[4] = 1'b1;
    joy_in[5] = 1'b1;
    for (int e = 0; e < 16; e++) begin
      step();
      if (e == 14) begin
        check("both_reset_req_n", 32'(reset_req_n), 32'd0);
        check("both_count", 32'(flap_count), 32'd1);
        check("both_button_n", 32'(button_n), 32'd0);
      end
    end
    check("fire_state", 32'(dut.r_state), 32'(FIRE));
    sys_reset = 1'b0;
    step();
    check("midfire_reset_req_n", 32'(reset_req_n), 32'd1);
    check("midfire_state", 32'(dut.r_state), 32'(IDLE));
    check("midfire_count", 32'(flap_count), 32'd0);
    check("midfire_button_n", 32'(button_n), 32'd1);
    $display("reset during fire: reset_req_n=%0b flap_count=%0d", reset_req_n, flap_count);
    joy_in    = 32'h0;
    idle(2);
    sys_reset = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
